// File: rtl/qsys_avalon_st_pkt_drop_fifo.sv
// Store-and-forward Avalon-ST packet FIFO: a packet is released only after an error-free EOP.
// Errored, overflowing and SOP-aborted packets are rolled back. Define QSYS_PKT_FIFO_STATS_EN for drop/commit counters.
module qsys_avalon_st_pkt_drop_fifo #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               in_error,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty
`ifdef QSYS_PKT_FIFO_STATS_EN
   ,
   output logic [15:0]        drop_count,
   output logic [15:0]        pkt_count
`endif
);
   localparam int PTR_W   = ADDR_W + 1;
   localparam int ENTRY_W = DATA_W + EMPTY_W + 2;
   localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, WR_PKT, WR_DISCARD} wr_state_t;

   wr_state_t          state_reg, state_next;
   logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]   commit_ptr_reg, commit_ptr_next;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W-1:0]   base_ptr;
   logic [PTR_W-1:0]   used_at_base;
   logic               in_ready_reg;
   logic               accept;
   logic               pkt_active;
   logic               full_hit;
   logic               wr_en;

   logic [ENTRY_W-1:0] ram [0:(1 << ADDR_W)-1];
   logic [ENTRY_W-1:0] ram_q_reg;
   logic               mid_valid_reg;
   logic               out_valid_reg;
   logic [ENTRY_W-1:0] out_entry_reg;
   logic               data_avail;
   logic               out_load;
   logic               rd_issue;

   assign accept       = in_valid && in_ready_reg;
   assign used_at_base = base_ptr - rd_ptr_reg;
   assign full_hit     = (used_at_base == DEPTH);

   // A new SOP always starts from commit_ptr, which silently drops any partial packet.
   always_comb begin
      state_next      = state_reg;
      wr_ptr_next     = wr_ptr_reg;
      commit_ptr_next = commit_ptr_reg;
      base_ptr        = wr_ptr_reg;
      pkt_active      = 1'b0;
      wr_en           = 1'b0;
      if (accept) begin
         if (in_startofpacket) begin
            base_ptr   = commit_ptr_reg;
            pkt_active = 1'b1;
         end else if (state_reg == WR_PKT) begin
            pkt_active = 1'b1;
         end else if (in_endofpacket) begin
            state_next = IDLE;
         end
         if (pkt_active) begin
            if (full_hit) begin
               wr_ptr_next = commit_ptr_reg;
               state_next  = in_endofpacket ? IDLE : WR_DISCARD;
            end else begin
               wr_en = 1'b1;
               if (!in_endofpacket) begin
                  wr_ptr_next = base_ptr + PTR_W'(1);
                  state_next  = WR_PKT;
               end else if (in_error) begin
                  wr_ptr_next = commit_ptr_reg;
                  state_next  = IDLE;
               end else begin
                  wr_ptr_next     = base_ptr + PTR_W'(1);
                  commit_ptr_next = base_ptr + PTR_W'(1);
                  state_next      = IDLE;
               end
            end
         end
      end
   end

   // Read side: RAM output register acts as a second slot behind the output register.
   assign data_avail = (rd_ptr_reg != commit_ptr_reg);
   assign out_load   = !out_valid_reg || out_ready;
   assign rd_issue   = data_avail && (!mid_valid_reg || out_load);

   always_ff @(posedge clk) begin
      if (wr_en)
         ram[base_ptr[ADDR_W-1:0]] <= {in_startofpacket, in_endofpacket, in_empty, in_data};
      if (rd_issue)
         ram_q_reg <= ram[rd_ptr_reg[ADDR_W-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         wr_ptr_reg     <= '0;
         commit_ptr_reg <= '0;
         rd_ptr_reg     <= '0;
         in_ready_reg   <= 1'b0;
         mid_valid_reg  <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_entry_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         wr_ptr_reg     <= wr_ptr_next;
         commit_ptr_reg <= commit_ptr_next;
         in_ready_reg   <= 1'b1;
         if (rd_issue) begin
            rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
            mid_valid_reg <= 1'b1;
         end else if (out_load) begin
            mid_valid_reg <= 1'b0;
         end
         if (out_load) begin
            out_valid_reg <= mid_valid_reg;
            if (mid_valid_reg)
               out_entry_reg <= ram_q_reg;
         end
      end
   end

   assign in_ready          = in_ready_reg;
   assign out_valid         = out_valid_reg;
   assign out_startofpacket = out_entry_reg[ENTRY_W-1];
   assign out_endofpacket   = out_entry_reg[ENTRY_W-2];
   assign out_empty         = out_entry_reg[DATA_W +: EMPTY_W];
   assign out_data          = out_entry_reg[DATA_W-1:0];

`ifdef QSYS_PKT_FIFO_STATS_EN
   logic        abort_evt;
   logic        err_evt;
   logic        ovf_evt;
   logic        commit_evt;
   logic [1:0]  drop_inc;
   logic [16:0] drop_sum;
   logic [15:0] drop_count_reg;
   logic [15:0] pkt_count_reg;

   // One accepted beat can both abort a partial packet and hit overflow or error.
   assign abort_evt  = accept && in_startofpacket && (state_reg == WR_PKT);
   assign err_evt    = wr_en && in_endofpacket && in_error;
   assign ovf_evt    = pkt_active && full_hit;
   assign commit_evt = (commit_ptr_next != commit_ptr_reg);
   assign drop_inc   = {1'b0, abort_evt} + {1'b0, err_evt} + {1'b0, ovf_evt};
   assign drop_sum   = {1'b0, drop_count_reg} + {15'd0, drop_inc};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         drop_count_reg <= '0;
         pkt_count_reg  <= '0;
      end else begin
         drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (commit_evt && (pkt_count_reg != 16'hFFFF))
            pkt_count_reg <= pkt_count_reg + 16'd1;
      end
   end

   assign drop_count = drop_count_reg;
   assign pkt_count  = pkt_count_reg;
`endif

endmodule

// File: tb/tb_qsys_avalon_st_pkt_drop_fifo.sv
// Directed bench for qsys_avalon_st_pkt_drop_fifo (16-entry buffer so overflow is cheap to reach).
// Output beats are collected on the falling edge and compared against hand-written expected beats.
`timescale 1ns/1ps
module tb_qsys_avalon_st_pkt_drop_fifo;
   localparam int ADDR_W = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_ready;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic [1:0]  in_empty;
   logic        in_error;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [1:0]  out_empty;
`ifdef QSYS_PKT_FIFO_STATS_EN
   logic [15:0] drop_count;
   logic [15:0] pkt_count;
`endif

   always #5 clk = ~clk;

   qsys_avalon_st_pkt_drop_fifo #(.ADDR_W(ADDR_W), .DATA_W(32), .EMPTY_W(2)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .in_error          (in_error),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_empty         (out_empty)
`ifdef QSYS_PKT_FIFO_STATS_EN
      ,
      .drop_count        (drop_count),
      .pkt_count         (pkt_count)
`endif
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [35:0] got_q[$];
   logic [35:0] exp_q[$];
   time         last_t;
   time         eop_t;
   time         rise_t = 0;
   logic        prev_valid = 1'b0;
   logic        tog_en = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [35:0] mk(input logic sop, input logic eop,
                                      input logic [1:0] emp, input logic [31:0] d);
      return {sop, eop, emp, d};
   endfunction

   // Output monitor: a transfer is out_valid && out_ready just before the next rising edge.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready)
         got_q.push_back({out_startofpacket, out_endofpacket, out_empty, out_data});
      if (out_valid && !prev_valid)
         rise_t <= $time;
      prev_valid <= out_valid;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (tog_en) out_ready = ~out_ready;
   end

   task automatic beat(input logic [31:0] d, input logic sop, input logic eop,
                       input logic [1:0] emp, input logic err);
      in_valid = 1'b1; in_data = d; in_startofpacket = sop;
      in_endofpacket = eop; in_empty = emp; in_error = err;
      @(posedge clk);
      last_t = $time;
      #1;
      in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
      in_empty = 2'd0; in_error = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int budget;
      logic [35:0] g;
      budget = 0;
      while (got_q.size() < exp_q.size() && budget < 300) begin
         @(posedge clk);
         budget++;
      end
      idle(10);
      chk({tag, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 36'hF_FFFF_FFFF;
         $display("%s beat %0d: got 0x%09h want 0x%09h", tag, i, g, exp_q[i]);
         chk($sformatf("%s beat %0d", tag, i), 64'(g), 64'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0;
      in_endofpacket = 1'b0; in_empty = '0; in_error = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst in_ready", 64'(in_ready), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_fields", 64'({out_startofpacket, out_endofpacket, out_empty, out_data}), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rel in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // 4-beat good packet, latency from EOP accept to out_valid
      beat(32'h11111111, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h22222222, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'h33333333, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'h44444444, 1'b0, 1'b1, 2'd2, 1'b0);
      eop_t = last_t;
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h11111111));
      exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h22222222));
      exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h33333333));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd2, 32'h44444444));
      drain("t1");
      chk("t1 latency ns", 64'(rise_t - eop_t), 64'd25);

      // Errored packet dropped, following good packet delivered
      beat(32'hA0000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'hA0000002, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'hA0000003, 1'b0, 1'b1, 2'd0, 1'b1);
      beat(32'hB0000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'hB0000002, 1'b0, 1'b1, 2'd1, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'hB0000001));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd1, 32'hB0000002));
      drain("t2");
`ifdef QSYS_PKT_FIFO_STATS_EN
      chk("t2 drop_count", 64'(drop_count), 64'd1);
      chk("t2 pkt_count", 64'(pkt_count), 64'd2);
`endif

      // 20-beat packet overflows the 16-entry buffer
      for (int i = 0; i < 20; i++)
         beat(32'hC0000000 + 32'(i), (i == 0), (i == 19), 2'd0, 1'b0);
      beat(32'hD0000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'hD0000002, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'hD0000003, 1'b0, 1'b1, 2'd3, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD0000001));
      exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'hD0000002));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd3, 32'hD0000003));
      drain("t3");

      // SOP without EOP aborted by a new SOP
      beat(32'h000000E1, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h000000E2, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'h000000F1, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h000000F2, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'h000000F3, 1'b0, 1'b1, 2'd2, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h000000F1));
      exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h000000F2));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd2, 32'h000000F3));
      drain("t4");
`ifdef QSYS_PKT_FIFO_STATS_EN
      chk("t4 drop_count", 64'(drop_count), 64'd3);
      chk("t4 pkt_count", 64'(pkt_count), 64'd4);
`endif

      // Two packets back to back with out_ready toggling
      tog_en = 1'b1;
      beat(32'h5A000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h5A000002, 1'b0, 1'b0, 2'd0, 1'b0);
      beat(32'h5A000003, 1'b0, 1'b1, 2'd3, 1'b0);
      beat(32'h6B000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h6B000002, 1'b0, 1'b1, 2'd0, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h5A000001));
      exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h5A000002));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd3, 32'h5A000003));
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h6B000001));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 32'h6B000002));
      drain("t5");
      tog_en = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Reset mid-packet with one committed packet waiting
      out_ready = 1'b0;
      beat(32'h77000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h77000002, 1'b0, 1'b1, 2'd0, 1'b0);
      idle(5);
      @(negedge clk);
      chk("t6 valid before rst", 64'(out_valid), 64'd1);
      chk("t6 data before rst", 64'(out_data), 64'h77000001);
      @(posedge clk); #1;
      beat(32'h88000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h88000002, 1'b0, 1'b0, 2'd0, 1'b0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("t6 valid after rst", 64'(out_valid), 64'd0);
      chk("t6 in_ready after rst", 64'(in_ready), 64'd0);
`ifdef QSYS_PKT_FIFO_STATS_EN
      chk("t6 drop_count rst", 64'(drop_count), 64'd0);
      chk("t6 pkt_count rst", 64'(pkt_count), 64'd0);
`endif
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("t6 idle");
      beat(32'h99000001, 1'b1, 1'b0, 2'd0, 1'b0);
      beat(32'h99000002, 1'b0, 1'b1, 2'd1, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h99000001));
      exp_q.push_back(mk(1'b0, 1'b1, 2'd1, 32'h99000002));
      drain("t6 new");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
